seq_alu: RTL and testbench

- Parametrised multi-cycle ALU; next generation of the team's 4-bit combinational ALU.
- Operand width is WIDTH. Results are registered 2*WIDTH bits, with a start/busy/done handshake and status flags.
- Single-cycle logic/add/sub. Iterative shift-add multiply and restoring divide.
- Sits behind the top-level pin wrapper; the wrapper maps pins to a, b, op and start.

---
 rtl/seq_alu.sv | 241 ++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU, single-cycle logic/add/sub, iterative MUL/DIV.
// Optional signed MUL/DIV with a fix-up cycle: define SEQ_ALU_SIGNED_EN.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_ALU_SIGNED_EN
  input  logic               sgn,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               flag_zero,
  output logic               flag_carry,
  output logic               flag_ovf,
  output logic               flag_dbz
);

  localparam int W = WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;
  localparam logic [2:0] OP_DIV = 3'd7;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   p_q, p_d;
  logic [W-1:0]     m_q, m_d;
  logic [2*W-1:0]   res_q, res_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic             s_en;
  logic             fix_w;
  logic [2*W-1:0]   fix_val;
  logic             a_neg, b_neg;
  logic [W-1:0]     am, bm;
  logic [W:0]       add_w, sub_w;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_nx;
  logic [W:0]       div_diff;
  logic [2*W-1:0]   div_nx;

  logic             fin;
  logic [2*W-1:0]   fin_val;
  logic             fin_c, fin_v, fin_dbz;

`ifdef SEQ_ALU_SIGNED_EN
  logic sgn_q, mulf_q, negp_q, negq_q, negr_q;
  logic [W-1:0] rem_f, quo_f;

  assign s_en  = sgn;
  assign fix_w = sgn_q;
  assign rem_f = negr_q ? (W'(0) - p_q[2*W-1:W]) : p_q[2*W-1:W];
  assign quo_f = negq_q ? (W'(0) - p_q[W-1:0]) : p_q[W-1:0];
  assign fix_val = mulf_q ? (negp_q ? ((2*W)'(0) - p_q) : p_q)
                          : {rem_f, quo_f};

  // Latch signedness and result sign fix-ups on each acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q  <= 1'b0;
      mulf_q <= 1'b0;
      negp_q <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (start && state_q == S_IDLE) begin
      sgn_q  <= sgn;
      mulf_q <= (op == OP_MUL);
      negp_q <= a_neg ^ b_neg;
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
    end
  end
`else
  assign s_en    = 1'b0;
  assign fix_w   = 1'b0;
  assign fix_val = p_q;
`endif

  assign a_neg = s_en & a[W-1];
  assign b_neg = s_en & b[W-1];
  assign am    = a_neg ? (W'(0) - a) : a;
  assign bm    = b_neg ? (W'(0) - b) : b;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};

  // Shift-add step: add multiplicand into the high half, shift right.
  assign mul_sum = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : '0);
  assign mul_nx  = {mul_sum, p_q[W-1:1]};

  // Restoring divide step: p holds {remainder, dividend/quotient}.
  assign div_diff = p_q[2*W-1:W-1] - {1'b0, m_q};
  assign div_nx   = div_diff[W] ? {p_q[2*W-2:0], 1'b0}
                                : {div_diff[W-1:0], p_q[W-2:0], 1'b1};

  // Next-state, datapath and result/flag selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    fin_val = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    fin_dbz = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          fin = 1'b1;
          unique case (op)
            OP_ADD: begin
              fin_val = {{(W-1){1'b0}}, add_w};
              fin_c   = add_w[W];
              fin_v   = (a[W-1] == b[W-1]) && (add_w[W-1] != a[W-1]);
            end
            OP_SUB: begin
              fin_val = {{W{1'b0}}, sub_w[W-1:0]};
              fin_c   = sub_w[W];
              fin_v   = (a[W-1] != b[W-1]) && (sub_w[W-1] != a[W-1]);
            end
            OP_AND: fin_val = {{W{1'b0}}, a & b};
            OP_OR:  fin_val = {{W{1'b0}}, a | b};
            OP_XOR: fin_val = {{W{1'b0}}, a ^ b};
            OP_NOT: fin_val = {{W{1'b0}}, ~a};
            OP_MUL: begin
              fin     = 1'b0;
              state_d = S_MUL;
              cnt_d   = '0;
              p_d     = {{W{1'b0}}, bm};
              m_d     = am;
            end
            default: begin
              if (b == '0) begin
                fin_val = {a, {W{1'b1}}};
                fin_dbz = 1'b1;
              end else begin
                fin     = 1'b0;
                state_d = S_DIV;
                cnt_d   = '0;
                p_d     = {{W{1'b0}}, am};
                m_d     = bm;
              end
            end
          endcase
        end
      end
      S_MUL, S_DIV: begin
        p_d   = (state_q == S_MUL) ? mul_nx : div_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          if (fix_w) begin
            state_d = S_FIX;
          end else begin
            state_d = S_IDLE;
            fin     = 1'b1;
            fin_val = p_d;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        fin     = 1'b1;
        fin_val = fix_val;
      end
    endcase
    if (fin) begin
      res_d   = fin_val;
      zero_d  = (fin_val == '0);
      carry_d = fin_c;
      ovf_d   = fin_v;
      dbz_d   = fin_dbz;
      done_d  = 1'b1;
    end
  end

  // State, datapath and registered result/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      res_q   <= res_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign result     = res_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;
  assign flag_dbz   = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu (WIDTH=8, unsigned build).
// Expected values come from an arithmetic model of each opcode.
module tb_seq_alu;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [2*W-1:0] result;
  logic          flag_zero, flag_carry, flag_ovf, flag_dbz;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] prev_res = '0;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .flag_dbz   (flag_dbz)
  );

  always #5 clk = ~clk;

  // Reference model: {dbz, ovf, carry, zero, result}.
  function automatic logic [2*W+3:0] model(input logic [2:0] o,
                                           input int unsigned x,
                                           input int unsigned y);
    int unsigned r, s;
    logic c, v, d;
    c = 0; v = 0; d = 0; r = 0;
    case (o)
      3'd0: begin
        s = x + y; r = s; c = (s > 255);
        v = (((x ^ y) & 128) == 0) && (((s ^ x) & 128) != 0);
      end
      3'd1: begin
        r = (x - y) & 255; c = (x < y);
        v = (((x ^ y) & 128) != 0) && (((r ^ x) & 128) != 0);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = (~x) & 255;
      3'd6: r = x * y;
      default: begin
        if (y == 0) begin r = (x << 8) | 255; d = 1; end
        else r = ((x % y) << 8) | (x / y);
      end
    endcase
    return {d, v, c, (r == 0), r[15:0]};
  endfunction

  function automatic int lat_of(input logic [2:0] o, input int unsigned y);
    if (o == 3'd6 || (o == 3'd7 && y != 0)) return W + 1;
    return 1;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit b2b,
                        input int poke);
    logic [2*W+3:0] e;
    int lat;
    e   = model(o, x, y);
    lat = lat_of(o, y);
    if (!b2b) begin
      @(negedge clk);
      tests++;
      assert (done === 1'b0) else begin
        fails++; $error("FAIL idle_done got=%b exp=0", done);
      end
    end
    start = 1'b1; op = o; a = x; b = y;
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      end
      if (n == poke + 1) start = 1'b0;
      if (n < lat) begin
        tests++;
        assert (busy === 1'b1 && done === 1'b0 && result === prev_res) else begin
          fails++;
          $error("FAIL busy_phase op=%0d n=%0d got busy=%b done=%b res=%h exp 1/0/%h",
                 o, n, busy, done, result, prev_res);
        end
        if (n == poke) begin start = 1'b1; op = 3'd0; end
      end else begin
        tests++;
        assert (done === 1'b1 && busy === 1'b0) else begin
          fails++; $error("FAIL done_pulse op=%0d got done=%b busy=%b exp 1/0", o, done, busy);
        end
        tests++;
        assert (result === e[2*W-1:0]) else begin
          fails++; $error("FAIL result op=%0d a=%h b=%h got=%h exp=%h", o, x, y, result, e[2*W-1:0]);
        end
        tests++;
        assert ({flag_dbz, flag_ovf, flag_carry, flag_zero} === e[2*W+3:2*W]) else begin
          fails++;
          $error("FAIL flags op=%0d a=%h b=%h got dbz/ovf/c/z=%b%b%b%b exp=%b",
                 o, x, y, flag_dbz, flag_ovf, flag_carry, flag_zero, e[2*W+3:2*W]);
        end
      end
    end
    prev_res = e[2*W-1:0];
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; op = 3'd0; a = 8'd1; b = 8'd1;
    repeat (3) @(negedge clk);
    rst = 1'b0; start = 1'b0;
    tests++;
    assert ({busy, done, result, flag_zero, flag_carry, flag_ovf, flag_dbz} === '0) else begin
      fails++; $error("FAIL reset_state got busy=%b done=%b res=%h", busy, done, result);
    end
    @(negedge clk);
    tests++;
    assert (done === 1'b0 && result === '0) else begin
      fails++; $error("FAIL reset_vs_start got done=%b res=%h exp 0/0", done, result);
    end

    run_op(3'd0, 8'd200, 8'd100, 0, 0);
    run_op(3'd1, 8'd5, 8'd7, 0, 0);
    run_op(3'd1, 8'h80, 8'h01, 0, 0);
    run_op(3'd0, 8'h7F, 8'h01, 0, 0);
    run_op(3'd6, 8'd255, 8'd255, 0, 3);
    repeat (3) begin
      @(negedge clk);
      tests++;
      assert (done === 1'b0 && busy === 1'b0) else begin
        fails++; $error("FAIL no_extra_done got done=%b busy=%b exp 0/0", done, busy);
      end
    end
    run_op(3'd7, 8'd200, 8'd7, 0, 0);
    run_op(3'd7, 8'h5A, 8'd0, 0, 0);
    run_op(3'd5, 8'hFF, 8'h00, 0, 0);
    run_op(3'd2, 8'hF0, 8'h3C, 0, 0);

    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 8'd3; b = 8'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    assert ({busy, done, result, flag_zero, flag_carry, flag_ovf, flag_dbz} === '0) else begin
      fails++; $error("FAIL abort_state got busy=%b done=%b res=%h exp 0", busy, done, result);
    end
    prev_res = '0;
    repeat (W + 2) begin
      @(negedge clk);
      tests++;
      assert (done === 1'b0) else begin
        fails++; $error("FAIL abort_no_done got=%b exp=0", done);
      end
    end
    run_op(3'd0, 8'd0, 8'd0, 0, 0);

    run_op(3'd6, 8'd13, 8'd11, 0, 0);
    run_op(3'd0, 8'd1, 8'd2, 1, 0);
    run_op(3'd7, 8'd255, 8'd16, 1, 0);
    run_op(3'd4, 8'hAA, 8'h55, 1, 0);

    for (int i = 0; i < 150; i++) begin
      logic [2:0] ro;
      logic [W-1:0] rx, ry;
      ro = 3'($urandom);
      rx = 8'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(ro, rx, ry, bit'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
